// File: rtl/divider_pkg.sv
// Shared encodings and constants for the 32-bit restoring divider.
package divider_pkg;

    typedef logic [1:0] div_op_t;

    // RV32M funct3 order: DIV, DIVU, REM, REMU
    localparam div_op_t OP_DIV  = 2'b00;
    localparam div_op_t OP_DIVU = 2'b01;
    localparam div_op_t OP_REM  = 2'b10;
    localparam div_op_t OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [31:0] SIGNED_MIN    = 32'h8000_0000;
    localparam int          ITER_COUNT    = 32;

    // Two's-complement magnitude; 0x80000000 maps onto itself, read as unsigned 2^31.
    function automatic logic [31:0] abs_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/divider_div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit, trial-subtract, select.
module div_step (
    input  logic [31:0] rem_in,
    input  logic        dividend_bit,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [31:0] diff;
    logic        borrow;

    // Bit 32 of the shifted value is folded into q_bit so one 33-bit subtract suffices.
    always_comb begin
        shifted          = {rem_in, dividend_bit};
        {borrow, diff}   = {1'b0, shifted[31:0]} - {1'b0, divisor};
        q_bit            = shifted[32] | ~borrow;
        rem_out          = q_bit ? diff : shifted[31:0];
    end

endmodule

// File: rtl/divider.sv
// Multi-cycle RV32M divider: one setup cycle, 32 restoring iterations, registered result.
// state | meaning
// IDLE  | waiting for start; start ignored while done is high
// CALC  | first cycle loads operand magnitudes, then one iteration per cycle
// FIN   | sign fix-up / special-case select, pulses done, back to IDLE
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] out
);

    localparam logic [5:0] LAST_ITER = 6'(ITER_COUNT - 1);

    logic [1:0]      state;
    logic            prep;
    logic [5:0]      cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q;
    logic            div0_q, ovf_q;

    logic            div0_in, ovf_in;
    logic            signed_q, rem_sel;
    logic [XLEN-1:0] step_rem;
    logic            step_q;
    logic [XLEN-1:0] q_res, r_res, result;

    div_step u_step (
        .rem_in       (rem_q),
        .dividend_bit (quo_q[XLEN-1]),
        .divisor      (div_q),
        .rem_out      (step_rem),
        .q_bit        (step_q)
    );

    always_comb begin
        div0_in  = (B == '0);
        ovf_in   = ((op == OP_DIV) || (op == OP_REM)) && (A == SIGNED_MIN) && (B == '1);
        signed_q = (op_q == OP_DIV) || (op_q == OP_REM);
        rem_sel  = (op_q == OP_REM) || (op_q == OP_REMU);
        q_res    = (signed_q && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? (~quo_q + 32'd1) : quo_q;
        r_res    = (signed_q && a_q[XLEN-1]) ? (~rem_q + 32'd1) : rem_q;
        if (div0_q)
            result = rem_sel ? a_q : DIV0_QUOTIENT;
        else if (ovf_q)
            result = rem_sel ? '0 : SIGNED_MIN;
        else
            result = rem_sel ? r_res : q_res;
        busy     = (state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            prep   <= 1'b0;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            div0_q <= 1'b0;
            ovf_q  <= 1'b0;
            done   <= 1'b0;
            out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !done) begin
                        op_q   <= op;
                        a_q    <= A;
                        b_q    <= B;
                        div0_q <= div0_in;
                        ovf_q  <= ovf_in;
                        prep   <= 1'b1;
                        cnt    <= '0;
                        state  <= (div0_in || ovf_in) ? ST_FIN : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (prep) begin
                        prep  <= 1'b0;
                        rem_q <= '0;
                        quo_q <= abs_if(a_q, signed_q);
                        div_q <= abs_if(b_q, signed_q);
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[XLEN-2:0], step_q};
                        if (cnt == LAST_ITER) begin
                            cnt   <= '0;
                            state <= ST_FIN;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                ST_FIN: begin
                    // Special cases skip CALC but still spend the setup cycle here.
                    if (prep) begin
                        prep <= 1'b0;
                    end else begin
                        out   <= result;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed RV32M cases, reset abort, and a random run.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] out;

    divider #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_done = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa, sbv;
        sa  = a;
        sbv = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sbv;
            2'b01:   return a / b;
            2'b10:   return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 2;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out", out, e.val);
                chk("latency", cyc, e.due);
                n_done++;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy || done) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // Returns on the negedge after the accepting posedge; operands are scrambled there.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        e.val = ref_div(o, a, b);
        e.due = cyc + lat_of(o, a, b);
        sb.push_back(e);
        n_acc++;
        start = 1'b0;
        op    = 2'($urandom_range(3));
        A     = $urandom;
        B     = $urandom;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out", out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 32'd100, 32'd7);
        issue(2'b11, 32'd100, 32'd7);
        issue(2'b00, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        issue(2'b01, 32'h1234_5678, 32'd0);
        issue(2'b10, 32'h1234_5678, 32'd0);
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        start = 1'b1;
        op    = 2'b01;
        A     = 32'd55;
        B     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b00, 32'h8000_0000, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        @(negedge clk);
        start = 1'b0;
        drain();

        issue(2'b01, 32'd9, 32'd4);
        begin
            int n = 0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
            end
            chk("done_seen", {31'd0, done}, 32'd1);
        end
        start = 1'b1;
        op    = 2'b01;
        A     = 32'd77;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);

        issue(2'b01, 32'd1000, 32'd3);
        repeat (12) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        n_acc--;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_out", out, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(2'b01, 32'd1000, 32'd3);
        drain();

        for (int i = 0; i < 1500; i++) begin
            logic [1:0]  o;
            logic [31:0] a, b;
            int          r;
            o = 2'($urandom_range(3));
            a = $urandom;
            r = $urandom_range(15);
            case (r)
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(15)) + 32'd1;
                2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(15));
                default: b = $urandom;
            endcase
            issue(o, a, b);
        end
        drain();
        chk("accepted_vs_done", n_done, n_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
